// File: rtl/mem_ni_packetizer.sv
// Memory-side NI: packs BODY_FLITS memory words into a HEAD/BODY/TAIL packet for the NoC injection FIFO.
// Define MEM_NI_SEQ_EN to add an 8-bit packet sequence number in HEAD[28:21].
module mem_ni_packetizer #(
  parameter logic [3:0] ID         = 4'h0,
  parameter int         DATA_W     = 24,
  parameter int         BODY_FLITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,
  input  logic [3:0]        dest_i,
  input  logic              fifo_full_i,
  output logic              fifo_wr_o,
  output logic [31:0]       fifo_wr_data_o,
  output logic              busy_o
);

  localparam int K        = DATA_W / 4;
  localparam int CHK_W    = K + 4;
  localparam int PAD_BODY = 30 - DATA_W;
  localparam int PAD_TAIL = 30 - CHK_W;
  localparam int CNT_W    = $clog2(BODY_FLITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BODY_FLITS - 1);
  localparam logic [3:0]       BF_FIELD = 4'(BODY_FLITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  // Row bits are per-nibble XORs, the top four bits are per-column XORs across nibbles.
  function automatic logic [CHK_W-1:0] par_f(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] p;
    p = {CHK_W{1'b0}};
    for (int i = 0; i < K; i++) begin
      p[i] = ^d[4*i +: 4];
      for (int j = 0; j < 4; j++) begin
        p[K+j] = p[K+j] ^ d[4*i+j];
      end
    end
    return p;
  endfunction

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       dest_r;
  logic [CHK_W-1:0] acc_r;
  logic [7:0]       seq_s;
  logic             fifo_wr_s;
  logic             mem_ready_s;
  logic [31:0]      flit_s;
  logic [31:0]      head_s;
  logic [31:0]      body_s;
  logic [31:0]      tail_s;

  assign head_s = {2'b00, 1'b1, seq_s, 4'b0000, BF_FIELD, dest_r, ID, 5'd25};
  assign body_s = {2'b01, {PAD_BODY{1'b0}}, mem_data_i};
  assign tail_s = {2'b11, {PAD_TAIL{1'b0}}, ~acc_r};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and combinational handshake/flit selection; a full FIFO freezes everything.
  always_comb begin
    next_state_s = state_r;
    fifo_wr_s    = 1'b0;
    mem_ready_s  = 1'b0;
    flit_s       = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (mem_valid_i) begin
          next_state_s = ST_HEAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HEAD: begin
        fifo_wr_s = ~fifo_full_i;
        flit_s    = head_s;
        if (fifo_wr_s) begin
          next_state_s = ST_BODY;
        end else begin
          next_state_s = ST_HEAD;
        end
      end
      ST_BODY: begin
        fifo_wr_s   = ~fifo_full_i & mem_valid_i;
        mem_ready_s = fifo_wr_s;
        flit_s      = body_s;
        if (fifo_wr_s && (cnt_r == CNT_LAST)) begin
          next_state_s = ST_TAIL;
        end else begin
          next_state_s = ST_BODY;
        end
      end
      ST_TAIL: begin
        fifo_wr_s = ~fifo_full_i;
        flit_s    = tail_s;
        if (fifo_wr_s && mem_valid_i) begin
          next_state_s = ST_HEAD;
        end else if (fifo_wr_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_TAIL;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Packet context: destination latch, body counter and parity accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      dest_r <= 4'h0;
      acc_r  <= {CHK_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_valid_i) begin
            dest_r <= dest_i;
            cnt_r  <= {CNT_W{1'b0}};
            acc_r  <= {CHK_W{1'b0}};
          end
        end
        ST_BODY: begin
          if (fifo_wr_s) begin
            acc_r <= acc_r ^ par_f(mem_data_i);
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_TAIL: begin
          if (fifo_wr_s && mem_valid_i) begin
            dest_r <= dest_i;
            cnt_r  <= {CNT_W{1'b0}};
            acc_r  <= {CHK_W{1'b0}};
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEM_NI_SEQ_EN
  logic [7:0] seq_r;

  // Sequence number advances once per written TAIL and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_r <= 8'h00;
    end else if ((state_r == ST_TAIL) && fifo_wr_s) begin
      seq_r <= seq_r + 8'd1;
    end
  end

  assign seq_s = seq_r;
`else
  assign seq_s = 8'h00;
`endif

  assign fifo_wr_o      = fifo_wr_s;
  assign mem_ready_o    = mem_ready_s;
  assign fifo_wr_data_o = flit_s;
  assign busy_o         = (state_r != ST_IDLE);

endmodule
